// File: rtl/mont_exp_ctrl_pkg.sv
// Shared constants, state encoding and exponent-length helpers for the
// Montgomery exponentiation controller.
package mont_exp_ctrl_pkg;

    localparam int N_W   = 514;
    localparam int E_W   = 512;
    localparam int LEN_W = 10;
    localparam int IDX_W = $clog2(E_W);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SQ_GO    = 4'd1,
        SQ_WAIT  = 4'd2,
        MUL_GO   = 4'd3,
        MUL_WAIT = 4'd4,
        NEXT     = 4'd5,
        FIN_GO   = 4'd6,
        FIN_WAIT = 4'd7,
        DONE     = 4'd8
    } state_t;

    localparam logic [N_W-1:0] ONE = {{(N_W-1){1'b0}}, 1'b1};

    // Lengths beyond the exponent register are treated as the full register.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(E_W)) begin
            return LEN_W'(E_W);
        end else begin
            return len;
        end
    endfunction

    // Index of the most significant processed bit; meaningless for len = 0.
    function automatic logic [IDX_W-1:0] first_index(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] m1;
        m1 = clamp_len(len) - LEN_W'(1);
        return m1[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery
// multiplier over a start/done handshake; ends with a MontMul by 1.
module mont_exp_ctrl
    import mont_exp_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [N_W-1:0]   in_x,
    input  logic [N_W-1:0]   in_r,
    input  logic [N_W-1:0]   in_m,
    input  logic [E_W-1:0]   in_e,
    input  logic [LEN_W-1:0] in_e_len,
    output logic [N_W-1:0]   result,
    output logic             done,
    output logic             busy,
    output logic             mul_start,
    output logic [N_W-1:0]   mul_a,
    output logic [N_W-1:0]   mul_b,
    output logic [N_W-1:0]   mul_m,
    input  logic [N_W-1:0]   mul_result,
    input  logic             mul_done
);

    state_t           state_r;
    logic [N_W-1:0]   a_r;
    logic [N_W-1:0]   x_r;
    logic [N_W-1:0]   m_r;
    logic [E_W-1:0]   e_r;
    logic [IDX_W-1:0] idx_r;
    logic [LEN_W-1:0] len_s;

    assign len_s = clamp_len(in_e_len);
    assign mul_m = m_r;

    // Controller FSM: operands and mul_start are loaded on entry to each *_GO
    // state so they are already registered and stable during the pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            a_r       <= '0;
            x_r       <= '0;
            m_r       <= '0;
            e_r       <= '0;
            idx_r     <= '0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        x_r       <= in_x;
                        a_r       <= in_r;
                        m_r       <= in_m;
                        e_r       <= in_e;
                        idx_r     <= first_index(in_e_len);
                        busy      <= 1'b1;
                        mul_start <= 1'b1;
                        mul_a     <= in_r;
                        if (len_s != '0) begin
                            mul_b   <= in_r;
                            state_r <= SQ_GO;
                        end else begin
                            mul_b   <= ONE;
                            state_r <= FIN_GO;
                        end
                    end
                end
                SQ_GO: begin
                    mul_start <= 1'b0;
                    state_r   <= SQ_WAIT;
                end
                SQ_WAIT: begin
                    if (mul_done) begin
                        a_r <= mul_result;
                        if (e_r[idx_r]) begin
                            mul_a     <= mul_result;
                            mul_b     <= x_r;
                            mul_start <= 1'b1;
                            state_r   <= MUL_GO;
                        end else begin
                            state_r   <= NEXT;
                        end
                    end
                end
                MUL_GO: begin
                    mul_start <= 1'b0;
                    state_r   <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (mul_done) begin
                        a_r     <= mul_result;
                        state_r <= NEXT;
                    end
                end
                NEXT: begin
                    mul_a     <= a_r;
                    mul_start <= 1'b1;
                    if (idx_r == '0) begin
                        mul_b   <= ONE;
                        state_r <= FIN_GO;
                    end else begin
                        idx_r   <= idx_r - IDX_W'(1);
                        mul_b   <= a_r;
                        state_r <= SQ_GO;
                    end
                end
                FIN_GO: begin
                    mul_start <= 1'b0;
                    state_r   <= FIN_WAIT;
                end
                FIN_WAIT: begin
                    if (mul_done) begin
                        result  <= mul_result;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    mul_start <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Standalone bench for mont_exp_ctrl with a behavioural Montgomery multiplier
// of programmable latency and a queue of expected results.
module tb_mont_exp_ctrl;
    import mont_exp_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [N_W-1:0]   in_x = '0, in_r = '0, in_m = '0;
    logic [E_W-1:0]   in_e = '0;
    logic [LEN_W-1:0] in_e_len = '0;
    logic [N_W-1:0]   result, mul_a, mul_b, mul_m;
    logic             done, busy, mul_start, mul_done;
    logic [N_W-1:0]   mul_result_v = '0;
    logic             md_model = 1'b0;
    logic             spur = 1'b0;

    typedef struct { longint unsigned res; int ops; } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0, n_bad = 0;
    int lat = 1, cnt = 0, total_ops = 0, overlap = 0, unstable = 0;
    int cyc = 0, last_md_cyc = 0;
    logic [N_W-1:0] cap_a, cap_b, cap_m, cap_res, last_b;
    longint unsigned rm, xm;

    assign mul_done = md_model | spur;

    mont_exp_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_e_len(in_e_len),
        .result(result), .done(done), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
        .mul_result(mul_result_v), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned pow2mod(input longint unsigned m);
        longint unsigned r = 1;
        for (int k = 0; k < N_W; k++) r = (r * 2) % m;
        return r;
    endfunction

    function automatic logic [N_W-1:0] mont_model(input logic [N_W-1:0] a, b, m);
        longint unsigned mm, r, rinv, p;
        logic [N_W-1:0] v;
        mm = m[63:0];
        v = '0;
        if (mm < 2) return v;
        r = pow2mod(mm);
        rinv = 0;
        for (longint unsigned k = 1; k < mm; k++) if ((r * k) % mm == 1) rinv = k;
        p = (((a[63:0] % mm) * (b[63:0] % mm)) % mm) * rinv % mm;
        v[63:0] = p;
        return v;
    endfunction

    // Behavioural multiplier: one op at a time, result after lat cycles.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= 0;
            md_model <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            md_model <= 1'b0;
            if (cnt != 0) begin
                if (mul_a !== cap_a || mul_b !== cap_b || mul_m !== cap_m) unstable <= unstable + 1;
                if (mul_start) overlap <= overlap + 1;
                if (cnt == 1) begin
                    md_model <= 1'b1;
                    mul_result_v <= cap_res;
                end
                cnt <= cnt - 1;
            end else if (mul_start) begin
                cap_a <= mul_a;
                cap_b <= mul_b;
                cap_m <= mul_m;
                last_b <= mul_b;
                cap_res <= mont_model(mul_a, mul_b, mul_m);
                total_ops <= total_ops + 1;
                if (lat <= 1) begin
                    md_model <= 1'b1;
                    mul_result_v <= mont_model(mul_a, mul_b, mul_m);
                end else begin
                    cnt <= lat - 1;
                end
            end
        end
    end

    // Remember the cycle of the most recent multiplier completion.
    always @(negedge clk) begin
        if (mul_done) last_md_cyc <= cyc;
    end

    task automatic launch(input longint unsigned x, r, m, e, input int len);
        @(negedge clk);
        in_x = '0; in_x[63:0] = x;
        in_r = '0; in_r[63:0] = r;
        in_m = '0; in_m[63:0] = m;
        in_e = '0; in_e[63:0] = e;
        in_e_len = LEN_W'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int base, output bit ok, output logic [N_W-1:0] res,
                           output int ops, output int gap);
        ok = 1'b0; res = '0; ops = 0; gap = 0;
        for (int k = 0; k < 30000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1; res = result; ops = total_ops - base; gap = cyc - last_md_cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (result !== '0 || mul_m !== '0) begin n_bad++; $display("FAIL reset_data: result=%0h mul_m=%0h, want 0", result[63:0], mul_m[63:0]); end
        n_cmp++; if ({done, busy, mul_start} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl: done/busy/mul_start=%b, want 000", {done, busy, mul_start}); end
        n_cmp++; if (mul_a !== '0 || mul_b !== '0) begin n_bad++; $display("FAIL reset_ops: mul_a=%0h mul_b=%0h, want 0", mul_a[63:0], mul_b[63:0]); end
        resetn = 1'b1;
    endtask

    task automatic run_and_check(input string name, input longint unsigned e, input int len);
        bit ok; logic [N_W-1:0] res, want; int ops, gap, base; exp_t x;
        base = total_ops;
        launch(xm, rm, 101, e, len);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b, want 1", name, busy); end
        collect(base, ok, res, ops, gap);
        x = exp_q.pop_front();
        want = '0; want[63:0] = x.res;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_timeout: no done seen, want done", name); end
        n_cmp++; if (res !== want) begin n_bad++; $display("FAIL %s_result: got %0d, want %0d", name, res[63:0], x.res); end
        n_cmp++; if (ops !== x.ops) begin n_bad++; $display("FAIL %s_ops: got %0d, want %0d", name, ops, x.ops); end
        n_cmp++; if (gap !== 1) begin n_bad++; $display("FAIL %s_latency: done %0d cycles after mul_done, want 1", name, gap); end
        n_cmp++; if (overlap !== 0 || unstable !== 0) begin n_bad++; $display("FAIL %s_handshake: overlap=%0d unstable=%0d, want 0/0", name, overlap, unstable); end
    endtask

    task automatic test_basic();
        lat = 1; exp_q.push_back('{48, 8});
        run_and_check("basic", 64'h11, 5);
    endtask

    task automatic test_leading_zeros();
        exp_q.push_back('{48, 11});
        run_and_check("lead0", 64'h11, 8);
    endtask

    task automatic test_len_zero();
        exp_q.push_back('{1, 1});
        run_and_check("len0", 64'h5a, 0);
        n_cmp++; if (last_b !== ONE) begin n_bad++; $display("FAIL len0_mul_b: got %0h, want 1", last_b[63:0]); end
    endtask

    task automatic test_latency();
        lat = 600; exp_q.push_back('{48, 8});
        run_and_check("lat600", 64'h11, 5);
        lat = 1; exp_q.push_back('{48, 8});
        run_and_check("lat1", 64'h11, 5);
    endtask

    task automatic test_clamp();
        exp_q.push_back('{48, E_W + 3});
        run_and_check("clamp", 64'h11, 1023);
    endtask

    task automatic test_start_while_busy();
        bit ok; logic [N_W-1:0] res; int ops, gap, base;
        lat = 5; base = total_ops; exp_q.push_back('{48, 8});
        launch(xm, rm, 101, 64'h11, 5);
        repeat (2) @(negedge clk);
        in_x = '0; in_x[7:0] = 8'd7; in_m = '0; in_m[7:0] = 8'd97;
        in_e = '0; in_e_len = LEN_W'(3); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_start_busy: got %b, want 1", busy); end
        collect(base, ok, res, ops, gap);
        n_cmp++; if (!ok || res[63:0] !== 64'(exp_q[0].res) || ops !== exp_q[0].ops) begin
            n_bad++; $display("FAIL busy_start_result: got %0d/%0d ops, want %0d/%0d ops", res[63:0], ops, exp_q[0].res, exp_q[0].ops);
        end
        void'(exp_q.pop_front());
        lat = 1;
    endtask

    task automatic test_back_to_back();
        int base;
        exp_q.push_back('{48, 8});
        run_and_check("b2b_first", 64'h11, 5);
        in_e_len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; base = total_ops;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL done_cycle_start_busy: got %b, want 0", busy); end
        repeat (4) @(negedge clk);
        n_cmp++; if (total_ops !== base) begin n_bad++; $display("FAIL done_cycle_start_ops: got %0d, want 0", total_ops - base); end
        n_cmp++; if (result[63:0] !== 64'd48) begin n_bad++; $display("FAIL result_hold: got %0d, want 48", result[63:0]); end
        exp_q.push_back('{48, 8});
        run_and_check("b2b_second", 64'h11, 5);
    endtask

    task automatic test_spurious_done();
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        @(negedge clk);
        n_cmp++; if (result[63:0] !== 64'd48 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL spurious_done: result=%0d busy=%b done=%b, want 48/0/0", result[63:0], busy, done);
        end
    endtask

    task automatic test_reset_mid();
        logic [N_W-1:0] xv; bit seen;
        xv = '0; xv[63:0] = xm; seen = 1'b0; lat = 20;
        exp_q.push_back('{48, 8});
        launch(xm, rm, 101, 64'h11, 5);
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            if (mul_start === 1'b1 && mul_b === xv) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_reach: multiply step not seen, want seen"); end
        repeat (2) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (result !== '0 || {done, busy, mul_start} !== 3'b000 || mul_a !== '0 || mul_b !== '0 || mul_m !== '0) begin
            n_bad++; $display("FAIL rstmid_outputs: busy=%b mul_a=%0h mul_m=%0h, want all 0", busy, mul_a[63:0], mul_m[63:0]);
        end
        exp_q.delete();
        @(negedge clk); resetn = 1'b1; lat = 1;
        exp_q.push_back('{48, 8});
        run_and_check("rstmid_fresh", 64'h11, 5);
    endtask

    initial begin
        rm = pow2mod(101);
        xm = (3 * rm) % 101;
        test_reset();
        test_basic();
        test_leading_zeros();
        test_len_zero();
        test_latency();
        test_clamp();
        test_start_while_busy();
        test_back_to_back();
        test_spurious_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
